imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter A_length, default 12, meaning instruction-memory byte-address width.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first fetch address after reset and the base of the instruction window.
REQ-003 SHALL have parameter Q_DEPTH, default 2, meaning the prefetch queue depth in entries.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: imem_addr  out  A_length  byte offset to memory; imem_rd  in  32  combinational read data for imem_addr.
REQ-006 SHALL have ports: redirect_valid  in  1  branch/jump request; redirect_pc  in  32  target address.
REQ-007 SHALL have ports: instr_valid  out  1  head entry valid; instr_ready  in  1  consumer accepts; instr  out  32  head word; instr_pc  out  32  head word's PC.
REQ-008 SHALL have port fault  out  1  fetch-window fault, present only when FETCH_FAULT_EN is defined.

Function
REQ-009 SHALL hold a 32-bit fetch PC; imem_addr = (pc - RESET_PC)[A_length-1:0], driven every cycle.
REQ-010 SHALL fetch when queue not full (or one entry dequeued this cycle), no redirect, and state RUN: at the clock edge, push {imem_rd, pc} and set pc <= pc + 4.
REQ-011 SHALL present the queue head on instr/instr_pc with instr_valid = queue not empty; entry leaves on instr_valid && instr_ready.
REQ-012 SHALL keep instr/instr_pc stable while instr_valid && !instr_ready.
REQ-013 SHALL give 1-cycle latency: word at pc visible on instr the cycle after the edge that fetched it.
REQ-014 SHALL sustain one instruction per cycle while instr_ready is held high.
REQ-015 SHALL, on redirect_valid at an edge: flush queue, set pc <= {redirect_pc[31:2], 2'b00}, push nothing; a simultaneous dequeue still counts as consumed.
REQ-016 SHALL ignore redirect_pc[1:0] (forced to zero).
REQ-017 SHALL wrap imem_addr modulo 2**A_length when pc passes the window top (0xBFC00FFC -> offset 0) when FETCH_FAULT_EN is undefined.
REQ-018 SHALL maintain count 0..Q_DEPTH; never push when full without a same-cycle pop; never pop when empty.

Reset
REQ-019 SHALL, on rst_n low, asynchronously set pc = RESET_PC, queue empty, instr_valid = 0, instr = 0, instr_pc = 0, state RUN, fault = 0.
REQ-020 SHALL discard any in-flight fetch when reset asserts mid-operation; first fetch at RESET_PC on the first edge after rst_n rises.

Configuration
REQ-021 SHALL compile window checking under macro IMEM_FETCH_FAULT_EN.
REQ-022 With IMEM_FETCH_FAULT_EN: states RUN, FAULT; RUN->FAULT at edge when pc outside [RESET_PC, RESET_PC + 2**A_length - 4] and no redirect; in FAULT no pushes, queued entries still drain, fault = 1; FAULT->RUN on redirect to an in-window PC; redirect out of window -> FAULT next edge.
REQ-023 Without IMEM_FETCH_FAULT_EN: no fault port, no FAULT state, wrap per REQ-017.

Structure
REQ-024 SHALL place IMEM_BASE (32'hBFC00000), IMEM_A_LENGTH (12) and fetch_state_t {RUN, FAULT} in package fetch_pkg.
REQ-025 SHALL implement the queue as sub-module fetch_queue (parameterised depth, push/pop, full/empty, flush).

Verification
REQ-026 Reset, instr_ready=1 -> imem_addr=0x000 first; instr_pc 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, instr = preloaded words.
REQ-027 instr_ready=0 for 5 cycles -> count saturates at 2, instr_pc stays 0xBFC00000, pc stops at 0xBFC00008.
REQ-028 Redirect to 0xBFC00102 with queue full -> next cycle instr_valid=0; following cycle instr_pc=0xBFC00100.
REQ-029 Redirect to 0xBFC00FFC, ready=1 -> without macro: next instr_pc 0xBFC01000 from offset 0; with macro: fault=1 after 0xBFC00FFC drains, no further valid until redirect to 0xBFC00000 clears fault.
REQ-030 Assert rst_n low mid-stream with queue holding 2 entries -> instr_valid drops immediately; refetch restarts at 0xBFC00000.
REQ-031 Redirect coincident with accepted handshake -> accepted word counted once, no duplicate, next instr_pc = target.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch controller.
package fetch_pkg;

  localparam logic [31:0] IMEM_BASE     = 32'hBFC00000;
  localparam int          IMEM_A_LENGTH = 12;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue holding {instr, pc} entries; flush empties it in one edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A full queue may still accept when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential PC, redirect, prefetch queue.
// Define IMEM_FETCH_FAULT_EN to enable fetch-window checking and the fault output.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          A_length = IMEM_A_LENGTH,
  parameter logic [31:0] RESET_PC = IMEM_BASE,
  parameter int          Q_DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [A_length-1:0] imem_addr,
  input  logic [31:0]         imem_rd,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc
`ifdef IMEM_FETCH_FAULT_EN
  ,output logic               fault
`endif
);

  logic         [31:0] pc;
  logic                run, push, pop, full, empty;
  fetch_entry_t        wdata, head;

`ifdef IMEM_FETCH_FAULT_EN
  fetch_state_t        state;
  logic         [31:0] off;
  logic                in_win;

  assign off       = pc - RESET_PC;
  assign in_win    = ((off >> A_length) == 32'd0);
  assign imem_addr = off[A_length-1:0];
  // Gate on the window as well so the out-of-window PC is never pushed.
  assign run       = (state == RUN) && in_win;
  assign fault     = (state == FAULT);

  // A redirect always re-enters RUN; a bad target faults on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        state <= RUN;
    else if (redirect_valid)           state <= RUN;
    else if (state == RUN && !in_win)  state <= FAULT;
  end
`else
  // Offset truncation gives the modulo-window wrap at the top of memory.
  assign imem_addr = A_length'(pc - RESET_PC);
  assign run       = 1'b1;
`endif

  assign pop         = instr_valid && instr_ready;
  assign push        = run && !redirect_valid && (!full || pop);
  assign wdata       = '{instr: imem_rd, pc: pc};
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
    else if (push)           pc <= pc + 32'd4;
  end

  fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a scoreboard of expected accepted PCs.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IMEM_FETCH_FAULT_EN
  logic        fault;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Memory contents are a pure function of the byte offset.
  assign imem_rd = 32'hC0DE0000 | {20'h0, imem_addr};

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return 32'hC0DE0000 | ((p - BASE) & 32'h0000_0FFF);
  endfunction

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IMEM_FETCH_FAULT_EN
    ,.fault         (fault)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", instr_pc, 32'hDEADDEAD);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, word_at(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", {20'd0, imem_addr}, 32'd0);

    // Streaming at one instruction per cycle.
    exp_q.push_back(BASE);
    exp_q.push_back(BASE + 4);
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    chk("s1_valid", {31'd0, instr_valid}, 32'd1);
    chk("s1_pc", instr_pc, BASE);
    chk("s1_addr", {20'd0, imem_addr}, 32'h4);
    tick();
    chk("s2_pc", instr_pc, BASE + 4);
    tick();
    chk("s3_pc", instr_pc, BASE + 8);
    instr_ready = 1'b0;
    tick();
    chk("hold_pc", instr_pc, BASE + 8);
    chk("hold_addr", {20'd0, imem_addr}, 32'h10);

    // Asynchronous reset with two entries queued.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    chk("arst_addr", {20'd0, imem_addr}, 32'd0);
    tick();

    // Back-pressure: queue saturates, head and PC stop.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_pc", instr_pc, BASE);
      chk("bp_instr", instr, word_at(BASE));
    end
    chk("bp_addr", {20'd0, imem_addr}, 32'h8);

    // Redirect with a full queue; low target bits ignored.
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h102;
    tick();
    chk("rd_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_addr", {20'd0, imem_addr}, 32'h100);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    exp_q.push_back(BASE + 32'h100);
    tick();
    chk("rd_pc", instr_pc, BASE + 32'h100);

    // Redirect on the same edge the head is accepted, into the window top.
    redirect_valid = 1'b1; redirect_pc = BASE + 32'hFFC;
    tick();
    chk("co_valid", {31'd0, instr_valid}, 32'd0);
    chk("co_addr", {20'd0, imem_addr}, 32'hFFC);
    redirect_valid = 1'b0;
`ifdef IMEM_FETCH_FAULT_EN
    exp_q.push_back(BASE + 32'hFFC);
    tick();
    chk("top_pc", instr_pc, BASE + 32'hFFC);
    tick();
    chk("flt_set", {31'd0, fault}, 32'd1);
    chk("flt_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("flt_hold", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = BASE;
    tick();
    chk("flt_clr", {31'd0, fault}, 32'd0);
    redirect_valid = 1'b0; instr_ready = 1'b0;
    tick();
    chk("flt_resume", instr_pc, BASE);
`else
    exp_q.push_back(BASE + 32'hFFC);
    exp_q.push_back(BASE + 32'h1000);
    tick();
    chk("top_pc", instr_pc, BASE + 32'hFFC);
    chk("wrap_addr", {20'd0, imem_addr}, 32'h0);
    tick();
    chk("wrap_pc", instr_pc, BASE + 32'h1000);
    chk("wrap_instr", instr, 32'hC0DE0000);
    tick();
    chk("wrap_next", instr_pc, BASE + 32'h1004);
    instr_ready = 1'b0;
`endif
    tick(); tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
